// File: rtl/axi_lite_arbiter_n.sv
// N-master AXI-lite arbiter: one transaction at a time is routed to the single xbar port.
// The grant is held from the address handshake until the final R or B handshake.
module axi_lite_arbiter_n #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int RR_MODE     = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_araddr,
    input  logic [NUM_MASTERS-1:0]        m_arvalid,
    output logic [NUM_MASTERS-1:0]        m_arready,
    output logic [NUM_MASTERS*DATA_W-1:0] m_rdata,
    output logic [NUM_MASTERS*2-1:0]      m_rresp,
    output logic [NUM_MASTERS-1:0]        m_rvalid,
    input  logic [NUM_MASTERS-1:0]        m_rready,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_awaddr,
    input  logic [NUM_MASTERS-1:0]        m_awvalid,
    output logic [NUM_MASTERS-1:0]        m_awready,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
    input  logic [NUM_MASTERS*DATA_W/8-1:0] m_wstrb,
    input  logic [NUM_MASTERS-1:0]        m_wvalid,
    output logic [NUM_MASTERS-1:0]        m_wready,
    output logic [NUM_MASTERS*2-1:0]      m_bresp,
    output logic [NUM_MASTERS-1:0]        m_bvalid,
    input  logic [NUM_MASTERS-1:0]        m_bready,
    output logic [ADDR_W-1:0]             arbiter_xbar_araddr,
    output logic                          arbiter_xbar_arvalid,
    output logic                          arbiter_xbar_rready,
    output logic [ADDR_W-1:0]             arbiter_xbar_awaddr,
    output logic                          arbiter_xbar_awvalid,
    output logic [DATA_W-1:0]             arbiter_xbar_wdata,
    output logic [DATA_W/8-1:0]           arbiter_xbar_wstrb,
    output logic                          arbiter_xbar_wvalid,
    output logic                          arbiter_xbar_bready,
    input  logic                          arbiter_xbar_arready,
    input  logic [DATA_W-1:0]             arbiter_xbar_rdata,
    input  logic [1:0]                    arbiter_xbar_rresp,
    input  logic                          arbiter_xbar_rvalid,
    input  logic                          arbiter_xbar_awready,
    input  logic                          arbiter_xbar_wready,
    input  logic [1:0]                    arbiter_xbar_bresp,
    input  logic                          arbiter_xbar_bvalid
);

    localparam int GW     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    state_t          state_r, state_s;
    logic [GW-1:0]   grant_r, grant_s;
    logic [GW-1:0]   rr_ptr_r, rr_ptr_s;
    logic            aw_done_r, aw_done_s;
    logic            w_done_r, w_done_s;
    logic [GW-1:0]   win_s;
    logic [GW-1:0]   scan_s;
    logic            found_s;
    logic [NUM_MASTERS-1:0] req_s;
    logic [NUM_MASTERS-1:0] gnt_oh_s;
    logic            ar_en_s, r_en_s, aw_en_s, w_en_s, b_en_s;
    logic            ar_hs_s, r_hs_s, aw_hs_s, w_hs_s, b_hs_s;

    logic [ADDR_W-1:0] araddr_a [NUM_MASTERS];
    logic [ADDR_W-1:0] awaddr_a [NUM_MASTERS];
    logic [DATA_W-1:0] wdata_a  [NUM_MASTERS];
    logic [STRB_W-1:0] wstrb_a  [NUM_MASTERS];

    function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] idx);
        return (int'(idx) == NUM_MASTERS - 1) ? {GW{1'b0}} : GW'(int'(idx) + 1);
    endfunction

    assign req_s = m_awvalid | m_arvalid;

    // Channel enables come only from registered state, so nothing leaks while idle.
    assign ar_en_s = (state_r == RD_ADDR);
    assign r_en_s  = (state_r == RD_DATA);
    assign aw_en_s = (state_r == WR_ADDR) & ~aw_done_r;
    assign w_en_s  = (state_r == WR_ADDR) & ~w_done_r;
    assign b_en_s  = (state_r == WR_RESP);

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_m
        assign araddr_a[i] = m_araddr[i*ADDR_W +: ADDR_W];
        assign awaddr_a[i] = m_awaddr[i*ADDR_W +: ADDR_W];
        assign wdata_a[i]  = m_wdata[i*DATA_W +: DATA_W];
        assign wstrb_a[i]  = m_wstrb[i*STRB_W +: STRB_W];
        assign gnt_oh_s[i] = (grant_r == GW'(i));
        assign m_arready[i] = ar_en_s & gnt_oh_s[i] & arbiter_xbar_arready;
        assign m_rvalid[i]  = r_en_s & gnt_oh_s[i] & arbiter_xbar_rvalid;
        assign m_rdata[i*DATA_W +: DATA_W] = (r_en_s & gnt_oh_s[i]) ? arbiter_xbar_rdata : {DATA_W{1'b0}};
        assign m_rresp[i*2 +: 2] = (r_en_s & gnt_oh_s[i]) ? arbiter_xbar_rresp : 2'b00;
        assign m_awready[i] = aw_en_s & gnt_oh_s[i] & arbiter_xbar_awready;
        assign m_wready[i]  = w_en_s & gnt_oh_s[i] & arbiter_xbar_wready;
        assign m_bvalid[i]  = b_en_s & gnt_oh_s[i] & arbiter_xbar_bvalid;
        assign m_bresp[i*2 +: 2] = (b_en_s & gnt_oh_s[i]) ? arbiter_xbar_bresp : 2'b00;
    end

    assign arbiter_xbar_araddr  = ar_en_s ? araddr_a[grant_r] : {ADDR_W{1'b0}};
    assign arbiter_xbar_arvalid = ar_en_s & m_arvalid[grant_r];
    assign arbiter_xbar_rready  = r_en_s & m_rready[grant_r];
    assign arbiter_xbar_awaddr  = aw_en_s ? awaddr_a[grant_r] : {ADDR_W{1'b0}};
    assign arbiter_xbar_awvalid = aw_en_s & m_awvalid[grant_r];
    assign arbiter_xbar_wdata   = w_en_s ? wdata_a[grant_r] : {DATA_W{1'b0}};
    assign arbiter_xbar_wstrb   = w_en_s ? wstrb_a[grant_r] : {STRB_W{1'b0}};
    assign arbiter_xbar_wvalid  = w_en_s & m_wvalid[grant_r];
    assign arbiter_xbar_bready  = b_en_s & m_bready[grant_r];

    assign ar_hs_s = arbiter_xbar_arvalid & arbiter_xbar_arready;
    assign r_hs_s  = r_en_s & arbiter_xbar_rvalid & m_rready[grant_r];
    assign aw_hs_s = arbiter_xbar_awvalid & arbiter_xbar_awready;
    assign w_hs_s  = arbiter_xbar_wvalid & arbiter_xbar_wready;
    assign b_hs_s  = b_en_s & arbiter_xbar_bvalid & m_bready[grant_r];

    // Winner selection: highest index in fixed mode, first upward from rr_ptr in round-robin.
    always_comb begin
        win_s   = {GW{1'b0}};
        scan_s  = {GW{1'b0}};
        found_s = 1'b0;
        if (RR_MODE == 0) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                win_s = req_s[i] ? GW'(i) : win_s;
            end
        end else begin
            for (int k = 0; k < NUM_MASTERS; k++) begin
                scan_s = GW'((int'(rr_ptr_r) + k) % NUM_MASTERS);
                if (!found_s && req_s[scan_s]) begin
                    win_s   = scan_s;
                    found_s = 1'b1;
                end else begin
                    found_s = found_s;
                end
            end
        end
    end

    // Next-state logic; write wins over read within the chosen master.
    always_comb begin
        state_s   = state_r;
        grant_s   = grant_r;
        rr_ptr_s  = rr_ptr_r;
        aw_done_s = aw_done_r;
        w_done_s  = w_done_r;
        case (state_r)
            IDLE: begin
                if (|req_s) begin
                    grant_s  = win_s;
                    state_s  = m_awvalid[win_s] ? WR_ADDR : RD_ADDR;
                    rr_ptr_s = (RR_MODE != 0) ? next_idx(win_s) : rr_ptr_r;
                end else begin
                    state_s = IDLE;
                end
            end
            RD_ADDR: begin
                if (ar_hs_s) state_s = RD_DATA;
                else         state_s = RD_ADDR;
            end
            RD_DATA: begin
                if (r_hs_s) state_s = IDLE;
                else        state_s = RD_DATA;
            end
            WR_ADDR: begin
                if ((aw_done_r | aw_hs_s) & (w_done_r | w_hs_s)) begin
                    state_s   = WR_RESP;
                    aw_done_s = 1'b0;
                    w_done_s  = 1'b0;
                end else begin
                    aw_done_s = aw_done_r | aw_hs_s;
                    w_done_s  = w_done_r | w_hs_s;
                end
            end
            WR_RESP: begin
                if (b_hs_s) state_s = IDLE;
                else        state_s = WR_RESP;
            end
            default: begin
                state_s   = IDLE;
                aw_done_s = 1'b0;
                w_done_s  = 1'b0;
            end
        endcase
    end

    // State, grant, round-robin pointer and write-phase flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            grant_r   <= {GW{1'b0}};
            rr_ptr_r  <= {GW{1'b0}};
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            grant_r   <= grant_s;
            rr_ptr_r  <= rr_ptr_s;
            aw_done_r <= aw_done_s;
            w_done_r  <= w_done_s;
        end
    end

endmodule

// File: tb/tb_axi_lite_arbiter_n.sv
// Directed bench: fixed-priority 2-master instance and round-robin 3-master instance.
module tb_axi_lite_arbiter_n;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // fixed priority, 2 masters
    logic [63:0] f_araddr, f_awaddr, f_wdata, f_rdata;
    logic [1:0]  f_arvalid, f_arready, f_rvalid, f_rready, f_awvalid, f_awready;
    logic [1:0]  f_wvalid, f_wready, f_bvalid, f_bready;
    logic [7:0]  f_wstrb;
    logic [3:0]  f_rresp, f_bresp;
    logic [31:0] f_x_araddr, f_x_awaddr, f_x_wdata, f_x_rdata;
    logic [3:0]  f_x_wstrb;
    logic        f_x_arvalid, f_x_rready, f_x_awvalid, f_x_wvalid, f_x_bready;
    logic        f_x_arready, f_x_rvalid, f_x_awready, f_x_wready, f_x_bvalid;
    logic [1:0]  f_x_rresp, f_x_bresp;

    // round robin, 3 masters
    logic [95:0] r_araddr, r_awaddr, r_wdata, r_rdata;
    logic [2:0]  r_arvalid, r_arready, r_rvalid, r_rready, r_awvalid, r_awready;
    logic [2:0]  r_wvalid, r_wready, r_bvalid, r_bready;
    logic [11:0] r_wstrb;
    logic [5:0]  r_rresp, r_bresp;
    logic [31:0] r_x_araddr, r_x_awaddr, r_x_wdata, r_x_rdata;
    logic [3:0]  r_x_wstrb;
    logic        r_x_arvalid, r_x_rready, r_x_awvalid, r_x_wvalid, r_x_bready;
    logic        r_x_arready, r_x_rvalid, r_x_awready, r_x_wready, r_x_bvalid;
    logic [1:0]  r_x_rresp, r_x_bresp;

    axi_lite_arbiter_n #(.NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32), .RR_MODE(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .m_araddr(f_araddr), .m_arvalid(f_arvalid), .m_arready(f_arready),
        .m_rdata(f_rdata), .m_rresp(f_rresp), .m_rvalid(f_rvalid), .m_rready(f_rready),
        .m_awaddr(f_awaddr), .m_awvalid(f_awvalid), .m_awready(f_awready),
        .m_wdata(f_wdata), .m_wstrb(f_wstrb), .m_wvalid(f_wvalid), .m_wready(f_wready),
        .m_bresp(f_bresp), .m_bvalid(f_bvalid), .m_bready(f_bready),
        .arbiter_xbar_araddr(f_x_araddr), .arbiter_xbar_arvalid(f_x_arvalid),
        .arbiter_xbar_rready(f_x_rready), .arbiter_xbar_awaddr(f_x_awaddr),
        .arbiter_xbar_awvalid(f_x_awvalid), .arbiter_xbar_wdata(f_x_wdata),
        .arbiter_xbar_wstrb(f_x_wstrb), .arbiter_xbar_wvalid(f_x_wvalid),
        .arbiter_xbar_bready(f_x_bready), .arbiter_xbar_arready(f_x_arready),
        .arbiter_xbar_rdata(f_x_rdata), .arbiter_xbar_rresp(f_x_rresp),
        .arbiter_xbar_rvalid(f_x_rvalid), .arbiter_xbar_awready(f_x_awready),
        .arbiter_xbar_wready(f_x_wready), .arbiter_xbar_bresp(f_x_bresp),
        .arbiter_xbar_bvalid(f_x_bvalid)
    );

    axi_lite_arbiter_n #(.NUM_MASTERS(3), .ADDR_W(32), .DATA_W(32), .RR_MODE(1)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .m_araddr(r_araddr), .m_arvalid(r_arvalid), .m_arready(r_arready),
        .m_rdata(r_rdata), .m_rresp(r_rresp), .m_rvalid(r_rvalid), .m_rready(r_rready),
        .m_awaddr(r_awaddr), .m_awvalid(r_awvalid), .m_awready(r_awready),
        .m_wdata(r_wdata), .m_wstrb(r_wstrb), .m_wvalid(r_wvalid), .m_wready(r_wready),
        .m_bresp(r_bresp), .m_bvalid(r_bvalid), .m_bready(r_bready),
        .arbiter_xbar_araddr(r_x_araddr), .arbiter_xbar_arvalid(r_x_arvalid),
        .arbiter_xbar_rready(r_x_rready), .arbiter_xbar_awaddr(r_x_awaddr),
        .arbiter_xbar_awvalid(r_x_awvalid), .arbiter_xbar_wdata(r_x_wdata),
        .arbiter_xbar_wstrb(r_x_wstrb), .arbiter_xbar_wvalid(r_x_wvalid),
        .arbiter_xbar_bready(r_x_bready), .arbiter_xbar_arready(r_x_arready),
        .arbiter_xbar_rdata(r_x_rdata), .arbiter_xbar_rresp(r_x_rresp),
        .arbiter_xbar_rvalid(r_x_rvalid), .arbiter_xbar_awready(r_x_awready),
        .arbiter_xbar_wready(r_x_wready), .arbiter_xbar_bresp(r_x_bresp),
        .arbiter_xbar_bvalid(r_x_bvalid)
    );

    logic f_any, r_any;
    assign f_any = |{f_arready, f_rvalid, f_awready, f_wready, f_bvalid, f_rdata, f_rresp, f_bresp,
                     f_x_araddr, f_x_arvalid, f_x_rready, f_x_awaddr, f_x_awvalid, f_x_wdata,
                     f_x_wstrb, f_x_wvalid, f_x_bready};
    assign r_any = |{r_arready, r_rvalid, r_awready, r_wready, r_bvalid, r_rdata, r_rresp, r_bresp,
                     r_x_araddr, r_x_arvalid, r_x_rready, r_x_awaddr, r_x_awvalid, r_x_wdata,
                     r_x_wstrb, r_x_wvalid, r_x_bready};

    // Simple xbar read slave for the round-robin instance: returns the address as data.
    always @(posedge clk) begin
        if (!rst_n) begin
            r_x_rvalid <= 1'b0;
            r_x_rdata  <= 32'h0;
        end else if (r_x_arvalid && r_x_arready) begin
            r_x_rvalid <= 1'b1;
            r_x_rdata  <= r_x_araddr;
        end else if (r_x_rvalid && r_x_rready) begin
            r_x_rvalid <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int exp_order [6] = '{0, 1, 2, 0, 1, 2};
        int n_ar;
        int r_tot;
        int idx;
        int rcnt [3];

        rst_n = 1'b0;
        f_araddr = 64'h0; f_awaddr = 64'h0; f_wdata = 64'h0; f_wstrb = 8'h0;
        f_arvalid = 2'b00; f_rready = 2'b11; f_awvalid = 2'b00; f_wvalid = 2'b00; f_bready = 2'b11;
        f_x_arready = 1'b1; f_x_rdata = 32'h1234_5678; f_x_rresp = 2'b11; f_x_rvalid = 1'b1;
        f_x_awready = 1'b1; f_x_wready = 1'b1; f_x_bresp = 2'b11; f_x_bvalid = 1'b1;
        r_araddr = 96'h0; r_awaddr = 96'h0; r_wdata = 96'h0; r_wstrb = 12'h0;
        r_arvalid = 3'b000; r_rready = 3'b000; r_awvalid = 3'b000; r_wvalid = 3'b000; r_bready = 3'b000;
        r_x_arready = 1'b0; r_x_rresp = 2'b00; r_x_awready = 1'b0; r_x_wready = 1'b0;
        r_x_bresp = 2'b00; r_x_bvalid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        settle();
        chk("rst_f_outs", {63'h0, f_any}, 64'h0);
        chk("rst_r_outs", {63'h0, r_any}, 64'h0);
        rst_n = 1'b1;
        step();
        settle();
        chk("idle_f_outs", {63'h0, f_any}, 64'h0);
        f_x_arready = 1'b0; f_x_rvalid = 1'b0; f_x_rresp = 2'b00; f_x_awready = 1'b0;
        f_x_wready = 1'b0; f_x_bvalid = 1'b0; f_x_bresp = 2'b00; f_bready = 2'b00;

        // simultaneous reads, highest index first
        f_arvalid = 2'b11;
        f_araddr  = {32'hA000_0000, 32'h8000_0000};
        settle();
        chk("a_grant_lat", {63'h0, f_x_arvalid}, 64'h0);
        step();
        settle();
        chk("a_addr_m1", f_x_araddr, 32'hA000_0000);
        chk("a_arvalid", f_x_arvalid, 1'b1);
        chk("a_arready_wait", f_arready, 2'b00);
        f_x_arready = 1'b1;
        settle();
        chk("a_arready_m1", f_arready, 2'b10);
        step();
        f_arvalid = 2'b01; f_x_arready = 1'b0;
        f_x_rvalid = 1'b1; f_x_rdata = 32'h1111_2222; f_x_rresp = 2'b10; f_rready = 2'b11;
        settle();
        chk("a_rvalid_m1", f_rvalid, 2'b10);
        chk("a_rdata_m1", f_rdata, {32'h1111_2222, 32'h0});
        chk("a_rresp_m1", f_rresp, 4'b1000);
        chk("a_rready_fwd", f_x_rready, 1'b1);
        step();
        f_x_rvalid = 1'b0; f_x_arready = 1'b1;
        settle();
        chk("a_bubble", {62'h0, f_x_arvalid, |f_arready}, 64'h0);
        step();
        settle();
        chk("a_addr_m0", f_x_araddr, 32'h8000_0000);
        chk("a_arready_m0", f_arready, 2'b01);
        step();
        f_arvalid = 2'b00; f_x_arready = 1'b0;
        f_x_rvalid = 1'b1; f_x_rdata = 32'h3333_4444; f_x_rresp = 2'b00;
        settle();
        chk("a_rdata_m0", f_rdata, {32'h0, 32'h3333_4444});
        step();
        f_x_rvalid = 1'b0;

        // m1 write, awready two cycles ahead of wready
        f_awvalid = 2'b10; f_wvalid = 2'b10;
        f_awaddr = {32'h0000_1000, 32'h0}; f_wdata = {32'hDEAD_BEEF, 32'h0}; f_wstrb = 8'hF0;
        settle();
        chk("b_grant_lat", {63'h0, f_x_awvalid}, 64'h0);
        step();
        f_x_awready = 1'b1; f_x_wready = 1'b0;
        settle();
        chk("b_awaddr", f_x_awaddr, 32'h0000_1000);
        chk("b_valids", {f_x_awvalid, f_x_wvalid}, 2'b11);
        chk("b_wdata", f_x_wdata, 32'hDEAD_BEEF);
        chk("b_wstrb", f_x_wstrb, 4'hF);
        chk("b_awready_pulse", f_awready, 2'b10);
        chk("b_wready_wait", f_wready, 2'b00);
        step();
        f_awvalid = 2'b00;
        settle();
        chk("b_awready_once", f_awready, 2'b00);
        chk("b_wvalid_on", f_x_wvalid, 1'b1);
        step();
        f_x_wready = 1'b1;
        settle();
        chk("b_wready_pulse", f_wready, 2'b10);
        chk("b_awready_still0", f_awready, 2'b00);
        step();
        f_wvalid = 2'b00; f_x_awready = 1'b0; f_x_wready = 1'b0;
        f_x_bvalid = 1'b1; f_x_bresp = 2'b00; f_bready = 2'b10;
        settle();
        chk("b_bvalid", f_bvalid, 2'b10);
        chk("b_bresp", f_bresp, 4'b0000);
        chk("b_bready_fwd", f_x_bready, 1'b1);
        step();
        f_x_bvalid = 1'b0; f_bready = 2'b00;

        // grant held through a stalled read while m1 requests a write
        f_arvalid = 2'b01; f_araddr = {32'h0, 32'h0000_0040};
        step();
        f_x_arready = 1'b1;
        settle();
        chk("c_arready_m0", f_arready, 2'b01);
        step();
        f_arvalid = 2'b00; f_x_arready = 1'b0; f_rready = 2'b01;
        f_awvalid = 2'b10; f_wvalid = 2'b10;
        f_awaddr = {32'h0000_2000, 32'h0}; f_wdata = {32'hCAFE_F00D, 32'h0};
        f_x_awready = 1'b1; f_x_wready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            settle();
            chk("c_hold_awready", f_awready, 2'b00);
            chk("c_hold_rready", f_x_rready, 1'b1);
            step();
        end
        f_x_rvalid = 1'b1; f_x_rdata = 32'h0000_0055;
        settle();
        chk("c_rvalid_m0", f_rvalid, 2'b01);
        step();
        f_x_rvalid = 1'b0;
        settle();
        chk("c_idle_gap", {62'h0, f_x_awvalid, |f_awready}, 64'h0);
        step();
        settle();
        chk("c_awaddr_m1", f_x_awaddr, 32'h0000_2000);
        chk("c_both_ready", {f_awready, f_wready}, 4'b1010);
        step();
        f_awvalid = 2'b00; f_wvalid = 2'b00; f_x_awready = 1'b0; f_x_wready = 1'b0;
        f_bready = 2'b10;
        settle();
        chk("c_in_wresp", f_x_bready, 1'b1);

        // reset while waiting for B, then a normal m0 read
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        settle();
        chk("rst_mid_outs", {63'h0, f_any}, 64'h0);
        f_bready = 2'b00;
        f_arvalid = 2'b01; f_araddr = {32'h0, 32'h0000_0044};
        settle();
        chk("d_grant_lat", {63'h0, f_x_arvalid}, 64'h0);
        step();
        f_x_arready = 1'b1;
        settle();
        chk("d_araddr", f_x_araddr, 32'h0000_0044);
        chk("d_arready", f_arready, 2'b01);
        step();
        f_arvalid = 2'b00; f_x_arready = 1'b0;
        f_x_rvalid = 1'b1; f_x_rdata = 32'h0000_0077; f_rready = 2'b01;
        settle();
        chk("d_rdata", f_rdata, {32'h0, 32'h0000_0077});
        step();
        f_x_rvalid = 1'b0;

        // round robin, three masters requesting continuously
        r_x_arready = 1'b1; r_rready = 3'b111; r_arvalid = 3'b111;
        r_araddr = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
        n_ar = 0; r_tot = 0;
        for (int i = 0; i < 3; i++) rcnt[i] = 0;
        for (int c = 0; c < 100 && r_tot < 6; c++) begin
            settle();
            if (r_x_arvalid && r_x_arready) begin
                idx = 7;
                for (int i = 0; i < 3; i++) if (r_arready[i]) idx = i;
                if (n_ar < 6) chk("rr_order", idx, exp_order[n_ar]);
                chk("rr_addr", r_x_araddr, (idx + 1) * 256);
                n_ar++;
            end
            for (int i = 0; i < 3; i++) begin
                if (r_rvalid[i] && r_rready[i]) begin
                    rcnt[i]++;
                    r_tot++;
                    chk("rr_rdata", r_rdata[i*32 +: 32], (i + 1) * 256);
                end
            end
            step();
        end
        chk("rr_ar_count", n_ar, 6);
        for (int i = 0; i < 3; i++) chk("rr_r_count", rcnt[i], 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
